// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        ls_rd_en,
    input  logic        ls_wr_en,
    input  logic [1:0]  ls_size,
    input  logic        ls_sign_ext,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic sel_ls, we_q, sext_q, err_q;
    logic [1:0] size_q, lane;
    logic [31:0] addr_q, wdata_q, shifted, ld_data;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic [3:0] strb;
    logic ls_any, any_req, pick_if, ls_bad, req_bad, tmo_hit;
    assign ls_any  = ls_rd_en | ls_wr_en;
    assign any_req = ls_any | if_req;
    // fetch wins only when idle LSU or after STARVE_MAX back-to-back LSU grants
    assign pick_if = if_req & (~ls_any | (starve_cnt == SW'(STARVE_MAX)));
    assign ls_bad  = (ls_rd_en & ls_wr_en) | (ls_size == 2'd3) |
                     ((ls_size == 2'd1) & ls_addr[0]) | ((ls_size == 2'd2) & |ls_addr[1:0]);
    assign req_bad = pick_if ? |if_addr[1:0] : ls_bad;
    assign tmo_hit = tmo_cnt == TW'(TIMEOUT - 1);
    assign lane    = addr_q[1:0];
    assign shifted = mem_rdata >> {lane, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld_data = (size_q == 2'd0) ? {{24{sext_q & ld_byte[7]}}, ld_byte} :
                     (size_q == 2'd1) ? {{16{sext_q & ld_half[15]}}, ld_half} : mem_rdata;
    assign strb    = (size_q == 2'd0) ? 4'b0001 << lane :
                     (size_q == 2'd1) ? 4'b0011 << lane : 4'b1111;
    assign mem_req   = state == ACCESS;
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign mem_wdata = (size_q == 2'd0) ? {4{wdata_q[7:0]}} :
                       (size_q == 2'd1) ? {2{wdata_q[15:0]}} : wdata_q;
    assign if_done   = (state == RESP) & ~sel_ls;
    assign ls_done   = (state == RESP) & sel_ls;
    assign if_err    = if_done & err_q;
    assign ls_err    = ls_done & err_q;
    assign busy      = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? (req_bad ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = (mem_ready | tmo_hit) ? RESP : ACCESS;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            sel_ls     <= 1'b0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                sel_ls     <= ~pick_if;
                we_q       <= ~pick_if & ls_wr_en;
                sext_q     <= ~pick_if & ls_sign_ext;
                size_q     <= pick_if ? 2'd2 : ls_size;
                addr_q     <= pick_if ? if_addr : ls_addr;
                wdata_q    <= ls_wdata;
                err_q      <= req_bad;
                tmo_cnt    <= '0;
                // an LSU grant over a waiting fetch can only occur below STARVE_MAX
                starve_cnt <= (~pick_if & if_req) ? starve_cnt + 1'b1 : '0;
            end else if (state == ACCESS) begin
                if (mem_ready) begin
                    if (!we_q && sel_ls) ls_rdata <= ld_data;
                    if (!we_q && !sel_ls) if_rdata <= mem_rdata;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    err_q   <= tmo_hit;
                end
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between instruction fetch and the load/store path driven by the decoder's rd_en/wr_en/size/sign_ext outputs.
- Arbitrates the two requesters and runs the memory req/ready handshake with a timeout.
- Generates byte strobes and lane-replicated write data, and aligns plus sign- or zero-extends load data.
- Sits between the core (fetch stage and memory stage) and the memory model.

Parameters:
- STARVE_MAX, 4: number of consecutive LSU grants allowed while if_req is pending before fetch is forced.
- TIMEOUT, 255: maximum number of ACCESS cycles to wait for mem_ready before aborting with an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held stable until if_done.
- if_addr  in  32  fetch address; word access.
- if_rdata  out  32  fetched word; registered and held until the next fetch completion.
- if_done  out  1  one-cycle completion pulse for fetch.
- if_err  out  1  valid with if_done: misaligned address or timeout.
- ls_rd_en  in  1  load request; held until ls_done.
- ls_wr_en  in  1  store request; held until ls_done.
- ls_size  in  2  access size: 0 byte, 1 halfword, 2 word, 3 illegal.
- ls_sign_ext  in  1  1 = sign-extend load data, 0 = zero-extend.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data, right-aligned.
- ls_rdata  out  32  aligned and extended load data; registered and held.
- ls_done  out  1  one-cycle completion pulse for load/store.
- ls_err  out  1  valid with ls_done.
- mem_req  out  1  memory request; high throughout ACCESS.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wstrb  out  4  byte-lane write strobes; 0000 on reads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data; valid when mem_ready is high.
- mem_ready  in  1  access complete; sampled only while mem_req is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset:
- rst low clears all state and outputs to 0 asynchronously, including mem_req, the strobes, the rdata registers, the starve counter and the timeout counter.
- Reset asserted mid-ACCESS drops mem_req immediately; no done pulse is issued for that access.

FSM states: IDLE, ACCESS, RESP.

IDLE:
- Arbitrate on the requests sampled this cycle.
- The LSU has priority when ls_rd_en|ls_wr_en is high, unless starve_cnt==STARVE_MAX and if_req is high; in that case fetch wins.
- Latch the winner's id, address, size, sign_ext and wdata.
- On a legal request, go to ACCESS; mem_req rises the next cycle.
- On an illegal request, go straight to RESP with err=1 and never assert mem_req. Illegal means any of:
  - ls_rd_en and ls_wr_en both high;
  - ls_size==3;
  - halfword with addr[0]==1;
  - word with addr[1:0]!=0;
  - fetch with if_addr[1:0]!=0.

ACCESS:
- Drive mem_req=1 plus mem_we, mem_addr, mem_wstrb and mem_wdata from the latched values, stable until exit.
- mem_ready=1 captures mem_rdata and moves to RESP with err=0.
- tmo_cnt increments each ACCESS cycle without mem_ready. When it reaches TIMEOUT, drop mem_req and go to RESP with err=1; the rdata output registers are left unchanged.

RESP:
- Pulse the winner's done for one cycle with err valid, then go to IDLE.
- The requester deasserts its request in the cycle after done, so IDLE never re-grants a finished request.

Timing and counters:
- Latency with a zero-wait memory (mem_ready high in the first ACCESS cycle): request in IDLE at cycle N, mem_req at N+1, done at N+2.
- starve_cnt increments on each LSU grant while if_req is high, saturating at STARVE_MAX.
- starve_cnt clears on a fetch grant, or on an LSU grant while if_req is low.

Write path (lane = addr[1:0]):
- byte: wstrb = 0001<<lane, wdata = {4{wdata[7:0]}}.
- halfword: wstrb = 0011<<lane, wdata = {2{wdata[15:0]}}.
- word: wstrb = 1111, wdata unchanged.
- All reads: wstrb = 0000.

Read path:
- byte: take mem_rdata[8*lane+7 : 8*lane].
- halfword: lane[1] selects bits [31:16] or [15:0].
- Extension to 32 bits is chosen by sign_ext.
- word: passed through unchanged.
- Fetch data is always the raw word.

Test Plan:
1. Store byte: ls_wr_en=1, size=0, addr=0x1003, wdata=0xAB, zero-wait memory -> mem_addr=0x1000, wstrb=1000, mem_wdata=0xABABABAB, ls_done at N+2, err=0.
2. Load half signed: addr=0x2002, sign_ext=1, mem_rdata=0x8001_1234 -> ls_rdata=0xFFFF8001; same access with sign_ext=0 -> 0x00008001.
3. Contention: both requesters high every cycle, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,fetch, repeating; no deadlock.
4. Misaligned word load at 0x3001 -> mem_req never asserted, ls_done with ls_err=1 at N+1; size=3 gives the same result.
5. Timeout: mem_ready held low, TIMEOUT=255 -> mem_req high for exactly 255 cycles, then if_done with if_err=1 and if_rdata unchanged.
6. Reset mid-ACCESS (3 wait states) -> mem_req and busy drop asynchronously, no done pulse; after release a fresh fetch completes normally.
